// File: rtl/conv_pkg.sv
// Shared definitions for the conv systolic array: default widths, the
// partial-sum word type and a saturating add helper.
package conv_pkg;

  localparam int unsigned X_W_DEF   = 8;
  localparam int unsigned W_W_DEF   = 8;
  localparam int unsigned Y_W_DEF   = 20;
  localparam int unsigned NUM_W_DEF = 4;

  typedef logic signed [Y_W_DEF-1:0] y_word_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_res_t;

  // Exact sum of two sign-extended operands, clamped to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w);
    sat_res_t           r;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.ovf = (s > hi) || (s < lo);
    if (s > hi)      r.val = hi;
    else if (s < lo) r.val = lo;
    else             r.val = s;
    return r;
  endfunction

endpackage

// File: rtl/pe_wbank.sv
// Weight bank for pe_mc: NUM_W x W_W register file with a wrapping write
// pointer and an asynchronous read port.
module pe_wbank
  import conv_pkg::*;
#(
  parameter int unsigned W_W   = W_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF,
  parameter int unsigned PTR_W = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             store_en,
  input  logic             ptr_clr,
  input  logic [W_W-1:0]   wdata,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [W_W-1:0]   rdata
);

  logic [W_W-1:0]   bank_q [NUM_W];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (ptr_clr) begin
      wr_ptr_d = '0;
    end else if (store_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_W - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
  end

  // The write uses the pre-clear pointer even when ptr_clr is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_W; i++) bank_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (store_en) bank_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign rdata = ({{(32-PTR_W){1'b0}}, rd_idx} < NUM_W) ? bank_q[rd_idx] : '0;

endmodule

// File: rtl/pe_mc.sv
// Multi-channel systolic PE: round-robin weight bank, signed/unsigned
// activations, valid lane, optional saturation and a sticky overflow flag.
module pe_mc
  import conv_pkg::*;
#(
  parameter int unsigned X_W    = X_W_DEF,
  parameter int unsigned W_W    = W_W_DEF,
  parameter int unsigned Y_W    = Y_W_DEF,
  parameter int unsigned NUM_W  = NUM_W_DEF,
  parameter int unsigned SAT_EN = 1,
  parameter int unsigned PTR_W  = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             store_en,
  input  logic             ptr_clr,
  input  logic             ovf_clr,
  input  logic             x_signed,
  input  logic [X_W-1:0]   in_x,
  input  logic             in_valid,
  input  logic [Y_W-1:0]   in_y,
  output logic [X_W-1:0]   out_x,
  output logic             out_valid,
  output logic [Y_W-1:0]   out_y,
  output logic [PTR_W-1:0] w_sel,
  output logic             ovf
);

  localparam int unsigned P_W = X_W + W_W + 1;

  logic [X_W-1:0]        reg_x_q;
  logic signed [Y_W-1:0] reg_y_q;
  logic                  reg_v_q;
  logic [PTR_W-1:0]      reg_sel_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic                  ovf_q;
  logic                  ovf_d;

  logic [W_W-1:0]        w_rd;
  logic signed [W_W-1:0] w_s;
  logic signed [X_W:0]   xe;
  logic signed [P_W-1:0] prod;
  logic signed [Y_W-1:0] y_wrap;
  sat_res_t              sat_r;
  logic [63-Y_W:0]       sat_unused_hi;

  pe_wbank #(
    .W_W   (W_W),
    .NUM_W (NUM_W),
    .PTR_W (PTR_W)
  ) u_wbank (
    .clk      (clk),
    .rst_n    (rst_n),
    .store_en (store_en),
    .ptr_clr  (ptr_clr),
    .wdata    (reg_x_q[W_W-1:0]),
    .rd_idx   (reg_sel_q),
    .rdata    (w_rd)
  );

  always_comb begin
    w_s    = w_rd;
    xe     = {x_signed & reg_x_q[X_W-1], reg_x_q};
    prod   = reg_v_q ? (P_W'(xe) * P_W'(w_s)) : '0;
    sat_r  = sat_add(64'(prod), 64'(reg_y_q), Y_W);
    y_wrap = reg_y_q + Y_W'(prod);
  end

  assign sat_unused_hi = sat_r.val[63:Y_W];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (ptr_clr) begin
      rd_ptr_d = '0;
    end else if (shift_en && in_valid) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(NUM_W - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    ovf_d = ovf_clr ? 1'b0 : (ovf_q | (reg_v_q & sat_r.ovf));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_x_q   <= '0;
      reg_y_q   <= '0;
      reg_v_q   <= 1'b0;
      reg_sel_q <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (shift_en) begin
        reg_x_q   <= in_x;
        reg_y_q   <= in_y;
        reg_v_q   <= in_valid;
        reg_sel_q <= rd_ptr_q;
      end
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_x     = reg_x_q;
  assign out_valid = reg_v_q;
  assign out_y     = (SAT_EN != 0) ? sat_r.val[Y_W-1:0] : y_wrap;
  assign w_sel     = reg_sel_q;
  assign ovf       = ovf_q;

endmodule
